dbus_responder: RTL and testbench

- Memory-side responder for the `dbus_req_t`/`dbus_resp_t` data-bus protocol; the core's data port is the initiator.
- Backs a word-addressed 64-bit RAM and answers each request after a configurable latency.
- Used as the simulation and FPGA data memory behind the core's MEM stage.
- Exercises the core's `MEM_wait` stall path with deterministic or jittered latency.

---
 rtl/dbus_responder_pkg.sv | 47 ++++
 rtl/dbus_responder_lfsr8.sv | 27 ++
 rtl/dbus_responder.sv | 149 ++++++++++++++
 tb/tb_dbus_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_responder_pkg.sv
// Shared data-bus types and defaults for the dbus responder.
// The optional latency-jitter path is selected by DBUS_RESPONDER_JITTER_EN.
package dbus_responder_pkg;

    typedef logic [2:0] msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    localparam logic [63:0] DBUS_RESP_BASE_DEFAULT    = 64'h8000_0000;
    localparam int          DBUS_RESP_DEPTH_DEFAULT   = 1024;
    localparam int          DBUS_RESP_LATENCY_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dresp_state_t;

    localparam logic [7:0] LFSR8_SEED = 8'hA5;

    // Byte-lane merge: lane i of the result comes from wdata when strobe[i] is set.
    function automatic logic [63:0] dbus_merge_bytes(input logic [63:0] old_word,
                                                     input logic [63:0] wdata,
                                                     input logic [7:0]  strobe);
        logic [63:0] merged;
        merged = old_word;
        for (int b = 0; b < 8; b++) begin
            if (strobe[b]) begin
                merged[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dbus_responder_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to jitter response latency.
// Only instantiated when DBUS_RESPONDER_JITTER_EN is defined.
module lfsr8
    import dbus_responder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    output logic [7:0] out
);

    logic [7:0] lfsr_q;
    logic       feedback;

    assign feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign out      = lfsr_q;

    // Advance one position per step; reseed on reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_q <= LFSR8_SEED;
        end else if (step) begin
            lfsr_q <= {lfsr_q[6:0], feedback};
        end
    end

endmodule

// File: rtl/dbus_responder.sv
// Memory-side responder for the dbus protocol: a word-addressed 64-bit RAM
// that answers each accepted request after a configurable latency.
// Define DBUS_RESPONDER_JITTER_EN to add 0..3 cycles of LFSR-driven jitter.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready; addr_ok follows dreq.valid, acceptance on this edge
// WAIT  | request latched, counting down to the response cycle
// RESP  | single cycle with data_ok (and oob if the address missed)
module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = DBUS_RESP_BASE_DEFAULT,
    parameter int          DEPTH     = DBUS_RESP_DEPTH_DEFAULT,
    parameter int          LATENCY   = DBUS_RESP_LATENCY_DEFAULT
)(
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       busy,
    output logic       oob
);

    localparam int IDX_W = $clog2(DEPTH);
`ifdef DBUS_RESPONDER_JITTER_EN
    localparam int CNT_W = 5;
`else
    localparam int CNT_W = 4;
`endif

    dresp_state_t     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_load;
    logic             data_ok_q;
    logic             oob_q;
    logic             oob_pend_q;
    logic             busy_q;
    logic [63:0]      rdata_q;

    logic [63:0]      mem_q [DEPTH] = '{default: '0};

    logic [63:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             in_win;
    logic             is_write;
    logic             accept;
    logic             unused_bits;

    // Address window decode and acceptance; the subtraction wraps for
    // addresses below the base, which the >= term rejects.
    always_comb begin
        offset   = dreq.addr - BASE_ADDR;
        idx      = offset[3 +: IDX_W];
        in_win   = (dreq.addr >= BASE_ADDR) && (offset[63:3] < 61'(DEPTH));
        is_write = |dreq.strobe;
        accept   = reset && (state_q == IDLE) && dreq.valid;
    end

    // Size is not needed (initiator pre-aligns) and the byte offset is ignored.
    assign unused_bits = ^{dreq.size, offset[2:0]};

`ifdef DBUS_RESPONDER_JITTER_EN
    logic [7:0] lfsr_out;
    logic       unused_lfsr;

    lfsr8 u_lfsr8 (
        .clk   (clk),
        .reset (reset),
        .step  (accept),
        .out   (lfsr_out)
    );

    // The LFSR value before this acceptance's step picks the extra delay.
    assign cnt_load    = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_out[1:0]);
    assign unused_lfsr = ^lfsr_out[7:2];
`else
    assign cnt_load = CNT_W'(LATENCY - 1);
`endif

    // Request FSM with registered data_ok/oob/busy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_ok_q  <= 1'b0;
            oob_q      <= 1'b0;
            oob_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            data_ok_q <= 1'b0;
            oob_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        oob_pend_q <= !in_win;
                        rdata_q    <= (!is_write && in_win) ? mem_q[idx] : 64'd0;
                        cnt_q      <= cnt_load;
                        busy_q     <= 1'b1;
                        if (cnt_load == '0) begin
                            state_q   <= RESP;
                            data_ok_q <= 1'b1;
                            oob_q     <= !in_win;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // The count reaching zero on this edge ends the wait.
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q   <= RESP;
                        data_ok_q <= 1'b1;
                        oob_q     <= oob_pend_q;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Writes commit on the acceptance edge; out-of-window writes are dropped.
    always_ff @(posedge clk) begin
        if (accept && is_write && in_win) begin
            mem_q[idx] <= dbus_merge_bytes(mem_q[idx], dreq.data, dreq.strobe);
        end
    end

    // Response bus: data is only driven during the data_ok cycle.
    always_comb begin
        dresp         = '0;
        dresp.addr_ok = accept;
        dresp.data_ok = data_ok_q;
        dresp.data    = data_ok_q ? rdata_q : 64'd0;
    end

    assign busy = busy_q;
    assign oob  = oob_q;

endmodule

// File: tb/tb_dbus_responder.sv
module tb_dbus_responder;
    import dbus_responder_pkg::*;

`ifdef DBUS_RESPONDER_JITTER_EN
    localparam int LAT = 1;
    localparam int JIT = 3;
`else
    localparam int LAT = 2;
    localparam int JIT = 0;
`endif
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          DEPTH = 1024;

    logic       clk = 1'b0;
    logic       reset;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    logic       busy;
    logic       oob;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] ref_mem [DEPTH];
`ifdef DBUS_RESPONDER_JITTER_EN
    bit   [3:0]  lat_seen = 4'h0;
`endif

    dbus_responder #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .LATENCY   (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .dreq  (dreq),
        .dresp (dresp),
        .busy  (busy),
        .oob   (oob)
    );

    always #5 clk = ~clk;

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic bit in_window(input logic [63:0] a);
        logic [63:0] off;
        off = a - BASE;
        return (a >= BASE) && ((off >> 3) < 64'(DEPTH));
    endfunction

    // Issue one request (call at posedge+1), follow it to its response and
    // check everything against the reference memory. Returns at RESP+4.
    task automatic transact(input string tag, input logic [63:0] a, input logic [7:0] s,
                            input logic [63:0] d, input bit scramble,
                            output int acc_wait, output logic busy_at_acc,
                            output logic [63:0] rd, output logic ob);
        logic [63:0] exp_rd;
        logic        exp_oob;
        int          lat;
        int          w;
        dreq.valid  = 1'b1;
        dreq.addr   = a;
        dreq.size   = 3'd3;
        dreq.strobe = s;
        dreq.data   = d;
        #3;
        acc_wait = 0;
        while (dresp.addr_ok !== 1'b1 && acc_wait < 50) begin
            @(posedge clk); #4;
            acc_wait++;
        end
        chk1({tag, "/addr_ok"}, dresp.addr_ok, 1'b1);
        chk1({tag, "/data_ok_at_accept"}, dresp.data_ok, 1'b0);
        busy_at_acc = busy;

        exp_oob = !in_window(a);
        exp_rd  = 64'd0;
        if (!exp_oob) begin
            w = int'((a - BASE) >> 3);
            if (s == 8'h00) begin
                exp_rd = ref_mem[w];
            end else begin
                for (int b = 0; b < 8; b++) begin
                    if (s[b]) ref_mem[w][b*8 +: 8] = d[b*8 +: 8];
                end
            end
        end

        lat = 0;
        do begin
            @(posedge clk); #1;
            if (scramble) begin
                dreq.valid  = 1'($urandom_range(0, 1));
                dreq.addr   = {$urandom, $urandom};
                dreq.strobe = 8'($urandom);
                dreq.data   = {$urandom, $urandom};
            end
            #3;
            lat++;
            chk1({tag, "/busy"}, busy, 1'b1);
            chk1({tag, "/addr_ok_while_busy"}, dresp.addr_ok, 1'b0);
            if (dresp.data_ok !== 1'b1) begin
                chk64({tag, "/data_outside_resp"}, dresp.data, 64'd0);
                chk1({tag, "/oob_outside_resp"}, oob, 1'b0);
            end
        end while (dresp.data_ok !== 1'b1 && lat < 40);

        chk1({tag, "/data_ok"}, dresp.data_ok, 1'b1);
        chk1({tag, "/latency"}, (lat >= LAT) && (lat <= LAT + JIT), 1'b1);
`ifdef DBUS_RESPONDER_JITTER_EN
        if (lat >= LAT && lat <= LAT + JIT) lat_seen[lat - LAT] = 1'b1;
`endif
        rd = dresp.data;
        ob = oob;
        chk64({tag, "/rdata"}, rd, exp_rd);
        chk1({tag, "/oob"}, ob, exp_oob);
    endtask

    initial begin
        int          aw;
        logic        bz;
        logic [63:0] rd;
        logic        ob;
        logic [63:0] a;
        logic [7:0]  s;
        int          sel;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 64'd0;

        // Reset held with a valid request pending.
        reset       = 1'b0;
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h8000_0010;
        dreq.size   = 3'd3;
        dreq.strobe = 8'h0F;
        dreq.data   = 64'h1122_3344_5566_7788;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #4;
            chk1("rst/addr_ok", dresp.addr_ok, 1'b0);
            chk1("rst/data_ok", dresp.data_ok, 1'b0);
            chk1("rst/busy", busy, 1'b0);
            chk1("rst/oob", oob, 1'b0);
            chk64("rst/data", dresp.data, 64'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;

        transact("wr10", 64'h8000_0010, 8'h0F, 64'h1122_3344_5566_7788, 1'b0, aw, bz, rd, ob);
        chk1("first_accept_after_reset", aw == 0, 1'b1);
        chk64("wr10/rdata_zero", rd, 64'd0);
        @(posedge clk); #1;
        transact("rd10", 64'h8000_0010, 8'h00, 64'd0, 1'b0, aw, bz, rd, ob);
        chk64("rd10/value", rd, 64'h0000_0000_5566_7788);
        @(posedge clk); #1;
        transact("rd14", 64'h8000_0014, 8'h00, 64'd0, 1'b0, aw, bz, rd, ob);
        chk64("rd14/value", rd, 64'h0000_0000_5566_7788);

        // Out-of-window accesses at both edges of the window.
        @(posedge clk); #1;
        transact("wr_below", 64'h7FFF_FFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, aw, bz, rd, ob);
        chk1("wr_below/oob", ob, 1'b1);
        @(posedge clk); #1;
        transact("rd_above", 64'h8000_2000, 8'h00, 64'd0, 1'b0, aw, bz, rd, ob);
        chk1("rd_above/oob", ob, 1'b1);
        chk64("rd_above/value", rd, 64'd0);
        @(posedge clk); #1;
        transact("rd_base", 64'h8000_0000, 8'h00, 64'd0, 1'b0, aw, bz, rd, ob);
        chk64("rd_base/unchanged", rd, 64'd0);
        @(posedge clk); #1;
        transact("wr_last", 64'h8000_1FF8, 8'hF0, 64'hCAFE_F00D_0000_0000, 1'b0, aw, bz, rd, ob);
        @(posedge clk); #1;
        transact("rd_last", 64'h8000_1FFF, 8'h00, 64'd0, 1'b0, aw, bz, rd, ob);
        chk64("rd_last/value", rd, 64'hCAFE_F00D_0000_0000);
        chk1("rd_last/oob", ob, 1'b0);

        // Back-to-back reads with valid held through RESP.
        @(posedge clk); #1;
        transact("b2b_a", 64'h8000_0010, 8'h00, 64'd0, 1'b0, aw, bz, rd, ob);
        @(posedge clk); #1;
        transact("b2b_b", 64'h8000_1FF8, 8'h00, 64'd0, 1'b0, aw, bz, rd, ob);
        chk1("b2b/accept_right_after_resp", aw == 0, 1'b1);
        chk1("b2b/busy_low_in_idle", bz, 1'b0);

        // Reset in the middle of a write: no response, write stays committed.
        @(posedge clk); #1;
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h8000_0100;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'hDEAD_BEEF_0BAD_F00D;
        #3;
        chk1("midrst/accept", dresp.addr_ok, 1'b1);
        ref_mem[32] = 64'hDEAD_BEEF_0BAD_F00D;
        @(posedge clk); #1;
        dreq.valid = 1'b0;
        reset      = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #4;
            chk1("midrst/data_ok", dresp.data_ok, 1'b0);
            chk1("midrst/busy", busy, 1'b0);
            chk1("midrst/oob", oob, 1'b0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        #3;
        chk1("midrst/no_late_data_ok", dresp.data_ok, 1'b0);
        @(posedge clk); #1;
        transact("midrst_rd", 64'h8000_0100, 8'h00, 64'd0, 1'b0, aw, bz, rd, ob);
        chk64("midrst_rd/value", rd, 64'hDEAD_BEEF_0BAD_F00D);

        // Random traffic against the reference memory.
        for (int i = 0; i < 1000; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)
                a = BASE - 64'($urandom_range(1, 64));
            else if (sel == 1)
                a = BASE + 64'(DEPTH * 8) + 64'($urandom_range(0, 64));
            else if (sel == 2)
                a = BASE + 64'((DEPTH - 1 - int'($urandom_range(0, 3))) * 8) + 64'($urandom_range(0, 7));
            else
                a = BASE + 64'($urandom_range(0, 15) * 8) + 64'($urandom_range(0, 7));
            s = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(1, 255));
            if ($urandom_range(0, 3) == 0) begin
                dreq.valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
            end
            @(posedge clk); #1;
            transact("rnd", a, s, {$urandom, $urandom}, 1'($urandom_range(0, 1)), aw, bz, rd, ob);
        end
        dreq.valid = 1'b0;

`ifdef DBUS_RESPONDER_JITTER_EN
        chk1("jitter/all_latencies_seen", lat_seen == 4'hF, 1'b1);
`endif

        @(posedge clk); #4;
        chk1("end/busy_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
